// File: rtl/uart_cmd_led_bank.sv
// -----------------------------------------------------------------------------
// uart_cmd_led_bank
//
// Framed command parser that drives a bank of active-low LEDs from the byte
// stream delivered by rx_module. A frame is four bytes:
//   SYNC (0x55), CMD, CH, CHK   with CHK = CMD ^ CH
// CMD: 0x33 ON (clear bit), 0x88 OFF (set bit), 0x5A TOGGLE (invert bit),
//      0xB1 BLINK (only when LED_BLINK_EN is defined).
// CH : 0..LED_NUM-1 addresses one channel, 0xFF addresses all channels.
//
// Optional feature macro: LED_BLINK_EN
//   Adds per-channel blink bits and a shared blink prescaler/phase. When the
//   macro is undefined, 0xB1 is an unknown command and no blink logic exists.
//
// Parameters:
//   LED_NUM    number of LED channels (1..16)
//   CLK_HZ     clk frequency in Hz
//   TIMEOUT_US maximum gap between bytes of one frame, in microseconds
//   BLINK_MS   blink half-period in ms (used only with LED_BLINK_EN)
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   rx_data    received byte
//   rx_valid   one-cycle strobe qualifying rx_data
//   led        LED drive, active-low (0 = lit)
//   frame_ok   one-cycle pulse: frame accepted and executed
//   frame_err  one-cycle pulse: frame rejected or timed out
//   busy       high while a frame is partially received (state != IDLE)
//
// Handshake: rx_valid/rx_data is a valid-only interface with no ready. The
// block accepts a byte in every cycle rx_valid is high, including the cycle
// right after a CHK byte, so back-to-back frames are never stalled.
// -----------------------------------------------------------------------------
module uart_cmd_led_bank #(
  parameter int LED_NUM    = 8,
  parameter int CLK_HZ     = 49152000,
  parameter int TIMEOUT_US = 2000,
  parameter int BLINK_MS   = 250
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic [LED_NUM-1:0] led,
  output logic               frame_ok,
  output logic               frame_err,
  output logic               busy
);

  localparam logic [7:0] SYNC_BYTE = 8'h55;
  localparam logic [7:0] CMD_ON    = 8'h33;
  localparam logic [7:0] CMD_OFF   = 8'h88;
  localparam logic [7:0] CMD_TOG   = 8'h5A;
  localparam logic [7:0] CH_ALL    = 8'hFF;

  // 64-bit math: CLK_HZ * TIMEOUT_US overflows 32 bits at the defaults, and
  // dividing CLK_HZ by 1e6 first would truncate 49.152 to 49.
  localparam longint TIMEOUT_CYC_L =
    (longint'(CLK_HZ) * longint'(TIMEOUT_US)) / longint'(1000000);
  localparam int TO_CLOG = $clog2(TIMEOUT_CYC_L);
  localparam int CNT_W   = (TO_CLOG < 17) ? 17 : TO_CLOG;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC_L - 1);

  // Elaboration-time guard on parameter ranges.
  if (LED_NUM < 1 || LED_NUM > 16 || BLINK_MS < 1 || TIMEOUT_CYC_L < 2) begin : g_bad_param
    $error("uart_cmd_led_bank: illegal parameter value");
  end

`ifdef LED_BLINK_EN
  localparam logic [7:0] CMD_BLINK = 8'hB1;
  localparam longint BLINK_CYC_L =
    (longint'(CLK_HZ) / longint'(1000)) * longint'(BLINK_MS);
  localparam int PRE_W = (BLINK_CYC_L > 2) ? $clog2(BLINK_CYC_L) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(BLINK_CYC_L - 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GET_CMD = 2'd1,
    S_GET_CH  = 2'd2,
    S_GET_CHK = 2'd3
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e             state_q, state_d;
  logic [7:0]         cmd_q, cmd_d;
  logic [7:0]         ch_q, ch_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LED_NUM-1:0] led_q, led_d;
  logic               frame_ok_q, frame_ok_d;
  logic               frame_err_q, frame_err_d;
  logic               busy_q, busy_d;

`ifdef LED_BLINK_EN
  logic [LED_NUM-1:0] blink_q, blink_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic               phase_q, phase_d;
`endif

  // Value currently shown on the pins; blinking channels follow the phase.
  logic [LED_NUM-1:0] led_disp;

`ifdef LED_BLINK_EN
  assign led_disp = (led_q & ~blink_q) | ({LED_NUM{phase_q}} & blink_q);
`else
  assign led_disp = led_q;
`endif

  // ---------------------------------------------------------------------------
  // Frame decode (evaluated against the CHK byte in GET_CHK)
  // ---------------------------------------------------------------------------
  logic [LED_NUM-1:0] ch_mask;
  logic               ch_legal;
  logic               cmd_known;
  logic               chk_match;
  logic               frame_good;

  always_comb begin
    ch_mask = '0;
    for (int i = 0; i < LED_NUM; i++) begin
      ch_mask[i] = (ch_q == CH_ALL) || (ch_q == 8'(i));
    end
    ch_legal  = (ch_q == CH_ALL) || (ch_q < 8'(LED_NUM));
    cmd_known = (cmd_q == CMD_ON) || (cmd_q == CMD_OFF) || (cmd_q == CMD_TOG)
`ifdef LED_BLINK_EN
                || (cmd_q == CMD_BLINK)
`endif
                ;
    chk_match  = (rx_data == (cmd_q ^ ch_q));
    frame_good = chk_match && cmd_known && ch_legal;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic timeout_hit;

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    ch_d        = ch_q;
    cnt_d       = cnt_q;
    led_d       = led_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
`ifdef LED_BLINK_EN
    blink_d     = blink_q;
`endif

    // rx_valid takes priority over the terminal count.
    timeout_hit = (state_q != S_IDLE) && !rx_valid && (cnt_q == TO_LAST);

    case (state_q)
      S_IDLE: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          state_d = S_GET_CMD;
        end
      end
      S_GET_CMD: begin
        if (rx_valid) begin
          cmd_d   = rx_data;
          state_d = S_GET_CH;
        end
      end
      S_GET_CH: begin
        if (rx_valid) begin
          ch_d    = rx_data;
          state_d = S_GET_CHK;
        end
      end
      S_GET_CHK: begin
        if (rx_valid) begin
          state_d = S_IDLE;
          if (frame_good) begin
            frame_ok_d = 1'b1;
            // ON/OFF/TOGGLE first stop any blinking on the addressed bits;
            // TOGGLE then inverts what the pin was actually showing.
            case (cmd_q)
              CMD_ON: begin
                led_d = led_q & ~ch_mask;
`ifdef LED_BLINK_EN
                blink_d = blink_q & ~ch_mask;
`endif
              end
              CMD_OFF: begin
                led_d = led_q | ch_mask;
`ifdef LED_BLINK_EN
                blink_d = blink_q & ~ch_mask;
`endif
              end
              CMD_TOG: begin
                led_d = (led_q & ~ch_mask) | (~led_disp & ch_mask);
`ifdef LED_BLINK_EN
                blink_d = blink_q & ~ch_mask;
`endif
              end
`ifdef LED_BLINK_EN
              CMD_BLINK: begin
                blink_d = blink_q | ch_mask;
              end
`endif
              default: begin
                led_d = led_q;
              end
            endcase
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Inter-byte timeout: runs only mid-frame, restarts on every byte.
    if (state_q == S_IDLE) begin
      cnt_d = '0;
    end else if (rx_valid) begin
      cnt_d = '0;
    end else if (timeout_hit) begin
      cnt_d       = '0;
      state_d     = S_IDLE;
      frame_err_d = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    busy_d = (state_d != S_IDLE);
  end

`ifdef LED_BLINK_EN
  // Shared free-running blink prescaler; phase flips once per half-period.
  always_comb begin
    pre_d   = pre_q + PRE_W'(1);
    phase_d = phase_q;
    if (pre_q == PRE_LAST) begin
      pre_d   = '0;
      phase_d = ~phase_q;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cmd_q       <= '0;
      ch_q        <= '0;
      cnt_q       <= '0;
      led_q       <= '1;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef LED_BLINK_EN
      blink_q     <= '0;
      pre_q       <= '0;
      phase_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      ch_q        <= ch_d;
      cnt_q       <= cnt_d;
      led_q       <= led_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
`ifdef LED_BLINK_EN
      blink_q     <= blink_d;
      pre_q       <= pre_d;
      phase_q     <= phase_d;
`endif
    end
  end

  assign led       = led_disp;
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule
